// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared opcode definitions for comparator_8bit and its
//                initiators (cmp_rule_sequencer).
//                Opcodes: GT=0 GTE=1 EQ=2 LT=3 LTE=4 NEVER=5 ALWAYS=6 NEQ=7
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_pkg;

  localparam int OPCODE_W = 3;

  localparam logic [OPCODE_W-1:0] OP_GT     = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_GTE    = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_EQ     = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_LT     = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_LTE    = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_NEVER  = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_ALWAYS = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_NEQ    = 3'd7;

endpackage
`default_nettype wire

// File: rtl/comparator_8bit.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_8bit
//  Description : Combinational unsigned 8-bit comparator, o_result = A op B,
//                forced to 0 when i_enable is low.
//  Ports       : i_a, i_b    8-bit unsigned operands
//                i_opcode    operation select (cmp_pkg OP_*)
//                i_enable    result gate
//                o_result    comparison result
//  Revision    : 1.0  initial release
// ============================================================================
module comparator_8bit
  import cmp_pkg::*;
(
  input  logic [7:0]          i_a,
  input  logic [7:0]          i_b,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_enable,
  output logic                o_result
);

  logic w_raw;

  always_comb begin
    w_raw = 1'b0;
    case (i_opcode)
      OP_GT:     w_raw = (i_a >  i_b);
      OP_GTE:    w_raw = (i_a >= i_b);
      OP_EQ:     w_raw = (i_a == i_b);
      OP_LT:     w_raw = (i_a <  i_b);
      OP_LTE:    w_raw = (i_a <= i_b);
      OP_NEVER:  w_raw = 1'b0;
      OP_ALWAYS: w_raw = 1'b1;
      OP_NEQ:    w_raw = (i_a != i_b);
      default:   w_raw = 1'b0;
    endcase
  end

  assign o_result = w_raw & i_enable;

endmodule
`default_nettype wire

// File: rtl/cmp_rule_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_rule_sequencer
//  Description : Programmable rule engine. Each accepted 8-bit sample is run
//                through N_RULES compare rules, one rule per cycle on a single
//                shared comparator_8bit; the per-rule match mask is returned
//                over valid/ready and hits are counted (saturating).
//  Ports       : clk, rst                       clock, sync active-high reset
//                cfg_we/cfg_ready/cfg_idx/...   rule table write port (IDLE only)
//                s_valid/s_ready/s_data         sample input stream
//                m_valid/m_ready/m_mask/m_any   result output stream
//                hit_cnt, cnt_clr               hit counter and its clear
//                busy                           engine not idle
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_rule_sequencer
  import cmp_pkg::*;
#(
  parameter  int N_RULES = 4,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  output logic                cfg_ready,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [OPCODE_W-1:0] cfg_opcode,
  input  logic [7:0]          cfg_operand,
  input  logic                cfg_enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [7:0]          s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_RULES-1:0]  m_mask,
  output logic                m_any,
  output logic [CNT_W-1:0]    hit_cnt,
  input  logic                cnt_clr,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // One extra bit so the slot bound can be compared even when N_RULES is a
  // power of two (then every cfg_idx value is in range).
  localparam logic [IDX_W:0]   c_N_RULES  = (IDX_W+1)'(N_RULES);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_RULES - 1);

  state_t                r_state;
  logic [OPCODE_W-1:0]   r_opcode  [N_RULES];
  logic [7:0]            r_operand [N_RULES];
  logic [N_RULES-1:0]    r_enable;
  logic [7:0]            r_sample;
  logic [IDX_W-1:0]      r_idx;
  logic [N_RULES-1:0]    r_mask;
  logic                  r_m_valid;
  logic                  r_s_ready;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_hit_cnt;

  logic w_cfg_take;
  logic w_s_take;
  logic w_m_take;
  logic w_cmp_result;

  // cfg_ready equals s_ready: both are high exactly in IDLE.
  assign w_cfg_take = cfg_we & r_s_ready & ({1'b0, cfg_idx} < c_N_RULES);
  assign w_s_take   = s_valid & r_s_ready;
  assign w_m_take   = r_m_valid & m_ready;

  comparator_8bit u_cmp (
    .i_a      (r_sample),
    .i_b      (r_operand[r_idx]),
    .i_opcode (r_opcode[r_idx]),
    .i_enable (r_enable[r_idx]),
    .o_result (w_cmp_result)
  );

  // Rule table. A write on the same edge as a sample accept lands before the
  // first EVAL cycle, so that sample already sees the new rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RULES; i++) begin
        r_opcode[i]  <= OP_NEVER;
        r_operand[i] <= 8'd0;
      end
      r_enable <= '0;
    end else if (w_cfg_take) begin
      r_opcode[cfg_idx]  <= cfg_opcode;
      r_operand[cfg_idx] <= cfg_operand;
      r_enable[cfg_idx]  <= cfg_enable;
    end
  end

  // Sequencer: IDLE -> EVAL (one rule per cycle) -> OUT (hold until taken).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_mask    <= '0;
      r_sample  <= 8'd0;
      r_m_valid <= 1'b0;
      r_s_ready <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_s_take) begin
            r_sample  <= s_data;
            r_mask    <= '0;
            r_idx     <= '0;
            r_state   <= S_EVAL;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_EVAL: begin
          r_mask[r_idx] <= w_cmp_result;
          if (r_idx == c_LAST_IDX) begin
            r_state   <= S_OUT;
            r_m_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_OUT: begin
          if (m_ready) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating hit counter; clear wins over a same-edge hit.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_m_take && (|r_mask) && (r_hit_cnt != '1)) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  assign cfg_ready = r_s_ready;
  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_mask    = r_mask;
  assign m_any     = |r_mask;
  assign hit_cnt   = r_hit_cnt;
  assign busy      = r_busy;

endmodule
`default_nettype wire
